// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the memory arbiter.
//   state_e      - arbiter FSM states
//   REQ_I, REQ_D - requester identifiers (instruction fetch / data port)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        RESP      = 2'd3
    } state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: grant selection between the instruction and data requesters.
//   i_valid_i    - instruction requester valid
//   d_valid_i    - data requester valid
//   last_grant_i - requester granted most recently (used only with MEM_ARB_RR_EN)
//   grant_o      - selected requester ID (meaningful when at least one valid is high)
// Build option: MEM_ARB_RR_EN selects round-robin on contention; otherwise data
// always wins over instruction.
module mem_arb_prio
    import mem_arb_pkg::*;
(
    input  logic i_valid_i,
    input  logic d_valid_i,
    input  logic last_grant_i,
    output logic grant_o
);

`ifdef MEM_ARB_RR_EN
    // On contention the requester that did not win last time is chosen.
    always_comb begin
        grant_o = REQ_D;
        if (i_valid_i && d_valid_i) begin
            grant_o = (last_grant_i == REQ_I) ? REQ_D : REQ_I;
        end else if (i_valid_i) begin
            grant_o = REQ_I;
        end
    end
`else
    // Fixed priority has no use for the pointer.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;

    always_comb begin
        grant_o = REQ_D;
        if (i_valid_i && !d_valid_i) begin
            grant_o = REQ_I;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch port and a data port onto a
// single memory port, one outstanding transaction at a time.
//   clk, reset           - clock and synchronous active-high reset
//   i_req_* / i_resp_*   - instruction fetch request (read only) and response
//   d_req_* / d_resp_*   - data request (read or write) and read response
//   mem_req_* / mem_resp_* - memory-side request and read response
//   stall                - high while a transaction is pending or in flight
// Build option: MEM_ARB_RR_EN enables round-robin grants on contention
// (default: data has fixed priority over instruction).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [ADDR_W-1:0]   i_req_addr,
    output logic                i_resp_valid,
    output logic [DATA_W-1:0]   i_resp_data,

    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic                d_req_rw,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_wmask,
    output logic                d_resp_valid,
    output logic [DATA_W-1:0]   d_resp_data,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_rw,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,

    output logic                stall
);

    state_e                state_q;
    logic                  id_q;
    logic                  rw_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wmask_q;
    logic [DATA_W-1:0]     i_rdata_q;
    logic [DATA_W-1:0]     d_rdata_q;

    logic grant_id;
    logic last_grant;
    logic idle;
    logic accept;

`ifdef MEM_ARB_RR_EN
    logic last_q;

    // Pointer starts at "instruction" so the first contended grant goes to data.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= REQ_I;
        end else if (accept) begin
            last_q <= grant_id;
        end
    end
    assign last_grant = last_q;
`else
    assign last_grant = REQ_I;
`endif

    mem_arb_prio u_prio (
        .i_valid_i    (i_req_valid),
        .d_valid_i    (d_req_valid),
        .last_grant_i (last_grant),
        .grant_o      (grant_id)
    );

    // Outputs are forced low during reset, independent of register contents.
    assign idle        = !reset && (state_q == IDLE);
    assign i_req_ready = idle && i_req_valid && (grant_id == REQ_I);
    assign d_req_ready = idle && d_req_valid && (grant_id == REQ_D);
    assign accept      = i_req_ready || d_req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            id_q      <= REQ_I;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        id_q    <= grant_id;
                        state_q <= ISSUE;
                        if (grant_id == REQ_D) begin
                            rw_q    <= d_req_rw;
                            addr_q  <= d_req_addr;
                            wdata_q <= d_req_wdata;
                            wmask_q <= d_req_wmask;
                        end else begin
                            // Instruction fetches are always reads with no write payload.
                            rw_q    <= 1'b0;
                            addr_q  <= i_req_addr;
                            wdata_q <= '0;
                            wmask_q <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        state_q <= rw_q ? IDLE : WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    // Each requester keeps its own data register so that one
                    // port's read never disturbs the other's held output.
                    if (mem_resp_valid) begin
                        if (id_q == REQ_I) begin
                            i_rdata_q <= mem_resp_data;
                        end else begin
                            d_rdata_q <= mem_resp_data;
                        end
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req_valid = !reset && (state_q == ISSUE);
    assign mem_req_rw    = rw_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;

    assign i_resp_valid  = !reset && (state_q == RESP) && (id_q == REQ_I);
    assign d_resp_valid  = !reset && (state_q == RESP) && (id_q == REQ_D);
    assign i_resp_data   = i_rdata_q;
    assign d_resp_data   = d_rdata_q;

    assign stall = !reset && ((state_q != IDLE) || i_req_valid || d_req_valid);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic GI = 1'b0;
    localparam logic GD = 1'b1;

    logic        clk;
    logic        reset;
    logic        i_req_valid, i_req_ready, i_resp_valid;
    logic [31:0] i_req_addr, i_resp_data;
    logic        d_req_valid, d_req_ready, d_req_rw, d_resp_valid;
    logic [31:0] d_req_addr, d_req_wdata, d_resp_data;
    logic [3:0]  d_req_wmask;
    logic        mem_req_valid, mem_req_ready, mem_req_rw, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_data;
    logic [3:0]  mem_req_wmask;
    logic        stall;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] exp_i_data;
    logic [31:0] exp_d_data;
    logic        last_grant;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req_valid   (i_req_valid),
        .i_req_ready   (i_req_ready),
        .i_req_addr    (i_req_addr),
        .i_resp_valid  (i_resp_valid),
        .i_resp_data   (i_resp_data),
        .d_req_valid   (d_req_valid),
        .d_req_ready   (d_req_ready),
        .d_req_rw      (d_req_rw),
        .d_req_addr    (d_req_addr),
        .d_req_wdata   (d_req_wdata),
        .d_req_wmask   (d_req_wmask),
        .d_resp_valid  (d_resp_valid),
        .d_resp_data   (d_resp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_rw    (mem_req_rw),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .stall         (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return ~a ^ 32'hC3C3_1234;
    endfunction

    task automatic mem_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
        logic [31:0] cur;
        cur = mem_read(a);
        for (int b = 0; b < 4; b++) begin
            if (m[b]) cur[b*8 +: 8] = wd[b*8 +: 8];
        end
        mem_model[a] = cur;
    endtask

    // Grant rule: a lone requester wins; on contention data wins, unless
    // round-robin is built in, in which case the one not granted last wins.
    function automatic logic model_grant(input logic iv, input logic dv);
        if (iv && !dv) return GI;
        if (dv && !iv) return GD;
        if (RR) return (last_grant == GI) ? GD : GI;
        return GD;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Plays memory for the next granted transaction, from handshake to return
    // to IDLE. Entered and left just after a rising edge with the FSM in IDLE.
    task automatic serve_next(input int rd, input int wd, output logic gid);
        logic        eid;
        logic        rw;
        logic [31:0] a, wdat, rdat;
        logic [3:0]  m;
        eid = model_grant(i_req_valid, d_req_valid);
        if (eid == GI) begin
            rw = 1'b0; a = i_req_addr; wdat = 32'h0; m = 4'h0;
        end else begin
            rw = d_req_rw; a = d_req_addr; wdat = d_req_wdata; m = d_req_wmask;
        end
        mem_req_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("hs_stall", 32'(stall), 32'd1);
        chk("hs_i_ready", 32'(i_req_ready), 32'(eid == GI));
        chk("hs_d_ready", 32'(d_req_ready), 32'(eid == GD));
        chk("hs_mem_valid", 32'(mem_req_valid), 32'd0);
        chk("hs_i_resp_valid", 32'(i_resp_valid), 32'd0);
        chk("hs_d_resp_valid", 32'(d_resp_valid), 32'd0);
        chk("hs_i_data_hold", i_resp_data, exp_i_data);
        chk("hs_d_data_hold", d_resp_data, exp_d_data);
        gid = d_req_ready ? GD : GI;
        last_grant = eid;
        cyc();
        if (eid == GI) i_req_valid = 1'b0;
        else d_req_valid = 1'b0;
        for (int k = 0; k <= rd; k++) begin
            mem_req_ready = (k == rd);
            @(negedge clk);
            chk("iss_valid", 32'(mem_req_valid), 32'd1);
            chk("iss_rw", 32'(mem_req_rw), 32'(rw));
            chk("iss_addr", mem_req_addr, a);
            chk("iss_wdata", mem_req_wdata, wdat);
            chk("iss_wmask", 32'(mem_req_wmask), 32'(m));
            chk("iss_stall", 32'(stall), 32'd1);
            chk("iss_no_accept", 32'(i_req_ready | d_req_ready), 32'd0);
            cyc();
        end
        mem_req_ready = 1'b0;
        if (rw) begin
            mem_write(a, wdat, m);
            return;
        end
        rdat = mem_read(a);
        for (int k = 0; k <= wd; k++) begin
            mem_resp_valid = (k == wd);
            mem_resp_data  = (k == wd) ? rdat : $urandom;
            mem_req_ready  = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("wr_mem_valid", 32'(mem_req_valid), 32'd0);
            chk("wr_resp_valid", 32'(i_resp_valid | d_resp_valid), 32'd0);
            chk("wr_stall", 32'(stall), 32'd1);
            cyc();
        end
        mem_resp_valid = 1'b0;
        mem_resp_data  = $urandom;
        mem_req_ready  = 1'($urandom_range(0, 1));
        if (eid == GI) exp_i_data = rdat;
        else exp_d_data = rdat;
        @(negedge clk);
        chk("rsp_i_valid", 32'(i_resp_valid), 32'(eid == GI));
        chk("rsp_d_valid", 32'(d_resp_valid), 32'(eid == GD));
        chk("rsp_i_data", i_resp_data, exp_i_data);
        chk("rsp_d_data", d_resp_data, exp_d_data);
        chk("rsp_stall", 32'(stall), 32'd1);
        cyc();
        mem_req_ready = 1'b0;
    endtask

    initial begin
        logic g;
        logic gseq [4];
        logic exp_seq [4];

        reset = 1'b1;
        i_req_valid = 1'b1; i_req_addr = 32'h0;
        d_req_valid = 1'b0; d_req_rw = 1'b0; d_req_addr = 32'h0;
        d_req_wdata = 32'h0; d_req_wmask = 4'h0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        exp_i_data = 32'h0; exp_d_data = 32'h0; last_grant = GI;

        // Reset: outputs gated even with a request pending
        @(negedge clk);
        chk("rst_i_ready", 32'(i_req_ready), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_valid", 32'(mem_req_valid), 32'd0);
        cyc();
        @(negedge clk);
        chk("rst_i_data", i_resp_data, 32'h0);
        chk("rst_d_data", d_resp_data, 32'h0);
        chk("rst_mem_addr", mem_req_addr, 32'h0);
        chk("rst_resp_valid", 32'(i_resp_valid | d_resp_valid), 32'd0);
        cyc();
        reset = 1'b0;
        i_req_valid = 1'b0;

        // Memory handshakes while idle with no request are ignored
        mem_resp_valid = 1'b1; mem_resp_data = 32'hA5A5_5A5A; mem_req_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_resp_valid", 32'(i_resp_valid | d_resp_valid), 32'd0);
            chk("idle_i_data", i_resp_data, 32'h0);
            chk("idle_d_data", d_resp_data, 32'h0);
            chk("idle_stall", 32'(stall), 32'd0);
            chk("idle_mem_valid", 32'(mem_req_valid), 32'd0);
            cyc();
        end
        mem_resp_valid = 1'b0; mem_req_ready = 1'b0;

        // Zero-wait instruction fetch of 0x100
        mem_model[32'h100] = 32'hDEAD_BEEF;
        i_req_valid = 1'b1; i_req_addr = 32'h100;
        serve_next(0, 0, g);
        chk("fetch_grant", 32'(g), 32'(GI));
        chk("fetch_data", i_resp_data, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("fetch_after_stall", 32'(stall), 32'd0);
        chk("fetch_after_valid", 32'(i_resp_valid), 32'd0);
        cyc();

        // Simultaneous instruction 0x200 and data read 0x400
        i_req_valid = 1'b1; i_req_addr = 32'h200;
        d_req_valid = 1'b1; d_req_rw = 1'b0; d_req_addr = 32'h400;
        d_req_wdata = 32'h0; d_req_wmask = 4'h0;
        serve_next(0, 1, g);
        chk("contend_first", 32'(g), 32'(GD));
        serve_next(1, 0, g);
        chk("contend_second", 32'(g), 32'(GI));

        // Data write held off by memory for three cycles
        d_req_valid = 1'b1; d_req_rw = 1'b1; d_req_addr = 32'h10;
        d_req_wdata = 32'h1234_5678; d_req_wmask = 4'hF;
        serve_next(3, 0, g);
        chk("write_grant", 32'(g), 32'(GD));
        @(negedge clk);
        chk("write_no_resp", 32'(d_resp_valid), 32'd0);
        chk("write_idle_mem", 32'(mem_req_valid), 32'd0);
        chk("write_idle_stall", 32'(stall), 32'd0);
        cyc();

        // Reset while waiting for read data, then a late response
        d_req_valid = 1'b1; d_req_rw = 1'b0; d_req_addr = 32'h40;
        @(negedge clk);
        chk("ab_accept", 32'(d_req_ready), 32'd1);
        cyc();
        d_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        chk("ab_issue", 32'(mem_req_valid), 32'd1);
        cyc();
        mem_req_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("ab_rst_stall", 32'(stall), 32'd0);
        chk("ab_rst_resp", 32'(i_resp_valid | d_resp_valid), 32'd0);
        cyc();
        reset = 1'b0;
        exp_i_data = 32'h0; exp_d_data = 32'h0; last_grant = GI;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("ab_late_resp", 32'(i_resp_valid | d_resp_valid), 32'd0);
        chk("ab_late_stall", 32'(stall), 32'd0);
        chk("ab_late_mem", 32'(mem_req_valid), 32'd0);
        cyc();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("ab_after_resp", 32'(i_resp_valid | d_resp_valid), 32'd0);
        chk("ab_after_d_data", d_resp_data, 32'h0);
        chk("ab_after_i_data", i_resp_data, 32'h0);
        cyc();

        // Both requesters continuously valid for four grants
        exp_seq[0] = GD; exp_seq[1] = RR ? GI : GD;
        exp_seq[2] = GD; exp_seq[3] = RR ? GI : GD;
        i_req_valid = 1'b1; i_req_addr = 32'h200;
        d_req_valid = 1'b1; d_req_rw = 1'b0; d_req_addr = 32'h400;
        for (int k = 0; k < 4; k++) begin
            serve_next(0, 0, g);
            gseq[k] = g;
            i_req_valid = 1'b1;
            d_req_valid = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr_grant%0d", k), 32'(gseq[k]), 32'(exp_seq[k]));
        end
        while (i_req_valid || d_req_valid) serve_next(0, 0, g);

        // Randomized traffic
        for (int it = 0; it < 24; it++) begin
            int mode;
            mode = $urandom_range(0, 2);
            i_req_addr  = 32'($urandom_range(0, 7)) << 2;
            d_req_addr  = 32'($urandom_range(0, 7)) << 2;
            d_req_rw    = 1'($urandom_range(0, 1));
            d_req_wdata = $urandom;
            d_req_wmask = 4'($urandom_range(0, 15));
            i_req_valid = (mode != 1);
            d_req_valid = (mode != 0);
            while (i_req_valid || d_req_valid) begin
                serve_next($urandom_range(0, 3), $urandom_range(0, 3), g);
            end
        end
        @(negedge clk);
        chk("end_stall", 32'(stall), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
